// File: rtl/branch_predictor.sv
// Branch target buffer with per-entry saturating direction counters.
// Combinational next-PC lookup for IF; registered training from resolved branches in ID.
module branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] lookup_pc_i,
  output logic              pred_hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_next_pc_o,
  input  logic              update_valid_i,
  input  logic [ADDR_W-1:0] update_pc_i,
  input  logic              update_taken_i,
  input  logic [ADDR_W-1:0] update_target_i,
  input  logic              update_pred_taken_i,
  output logic [STAT_W-1:0] branch_cnt_o,
  output logic [STAT_W-1:0] mispredict_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_WEAK = CNT_W'(1) << (CNT_W - 1);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic              valid_q  [ENTRIES];
  logic              valid_d  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_d    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [ADDR_W-1:0] target_d [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];
  logic [CNT_W-1:0]  cnt_d    [ENTRIES];

  logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [STAT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_hit;
  logic             unused_pc_bits;

  assign lk_idx  = lookup_pc_i[IDX_W+1:2];
  assign lk_tag  = lookup_pc_i[ADDR_W-1:IDX_W+2];
  assign upd_idx = update_pc_i[IDX_W+1:2];
  assign upd_tag = update_pc_i[ADDR_W-1:IDX_W+2];

  // Instruction addresses are word aligned; the byte offset carries no information.
  assign unused_pc_bits = ^update_pc_i[1:0];

  // Lookup sees the registered table only, so a same-cycle update is not bypassed.
  always_comb begin
    pred_hit_o     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken_o   = pred_hit_o && cnt_q[lk_idx][CNT_W-1];
    pred_next_pc_o = pred_taken_o ? target_q[lk_idx] : lookup_pc_i + ADDR_W'(4);
  end

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (update_valid_i) begin
      if (upd_hit) begin
        if (update_taken_i) begin
          if (cnt_q[upd_idx] != CNT_MAX) begin
            cnt_d[upd_idx] = cnt_q[upd_idx] + CNT_W'(1);
          end
          target_d[upd_idx] = update_target_i;
        end else if (cnt_q[upd_idx] != '0) begin
          cnt_d[upd_idx] = cnt_q[upd_idx] - CNT_W'(1);
        end
      end else if (update_taken_i) begin
        // Taken miss allocates or evicts the aliasing entry, starting weakly taken.
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = update_target_i;
        cnt_d[upd_idx]    = CNT_WEAK;
      end
    end
  end

  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (update_valid_i) begin
      if (branch_cnt_q != STAT_MAX) begin
        branch_cnt_d = branch_cnt_q + STAT_W'(1);
      end
      if ((update_taken_i != update_pred_taken_i) && (mispredict_cnt_q != STAT_MAX)) begin
        mispredict_cnt_d = mispredict_cnt_q + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= valid_d[i];
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (16 entries, 2-bit counters, 4-bit statistics).
// Expected values are hand-computed and tracked alongside the stimulus.
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic [31:0] lookup_pc_i = '0;
  logic        pred_hit_o;
  logic        pred_taken_o;
  logic [31:0] pred_next_pc_o;
  logic        update_valid_i = 1'b0;
  logic [31:0] update_pc_i = '0;
  logic        update_taken_i = 1'b0;
  logic [31:0] update_target_i = '0;
  logic        update_pred_taken_i = 1'b0;
  logic [3:0]  branch_cnt_o;
  logic [3:0]  mispredict_cnt_o;

  int total = 0;
  int bad = 0;

  branch_predictor #(
    .ADDR_W(32), .ENTRIES(16), .CNT_W(2), .STAT_W(4)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .lookup_pc_i(lookup_pc_i),
    .pred_hit_o(pred_hit_o),
    .pred_taken_o(pred_taken_o),
    .pred_next_pc_o(pred_next_pc_o),
    .update_valid_i(update_valid_i),
    .update_pc_i(update_pc_i),
    .update_taken_i(update_taken_i),
    .update_target_i(update_target_i),
    .update_pred_taken_i(update_pred_taken_i),
    .branch_cnt_o(branch_cnt_o),
    .mispredict_cnt_o(mispredict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Stimulus helpers only; all comparisons live in the test tasks.
  task automatic set_lookup(input logic [31:0] pc);
    lookup_pc_i = pc;
    #1;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic taken,
                           input logic [31:0] target, input logic pred);
    update_valid_i      = 1'b1;
    update_pc_i         = pc;
    update_taken_i      = taken;
    update_target_i     = target;
    update_pred_taken_i = pred;
    @(posedge clk_i);
    #1;
    update_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    set_lookup(32'h40);
    total++;
    if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b0, 1'b0, 32'h44}) begin
      bad++;
      $display("FAIL reset_lookup got hit=%b taken=%b next=%h exp hit=0 taken=0 next=00000044",
               pred_hit_o, pred_taken_o, pred_next_pc_o);
    end
    total++;
    if ({branch_cnt_o, mispredict_cnt_o} !== 8'h00) begin
      bad++;
      $display("FAIL reset_stats got br=%0d mp=%0d exp br=0 mp=0", branch_cnt_o, mispredict_cnt_o);
    end
    set_lookup(32'hFFFF_FFFC);
    total++;
    if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b0, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL reset_wrap got hit=%b taken=%b next=%h exp hit=0 taken=0 next=00000000",
               pred_hit_o, pred_taken_o, pred_next_pc_o);
    end
  endtask

  task automatic test_alloc;
    do_update(32'h40, 1'b1, 32'h20, 1'b0);
    set_lookup(32'h40);
    total++;
    if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b1, 1'b1, 32'h20}) begin
      bad++;
      $display("FAIL alloc_lookup got hit=%b taken=%b next=%h exp hit=1 taken=1 next=00000020",
               pred_hit_o, pred_taken_o, pred_next_pc_o);
    end
    total++;
    if ({branch_cnt_o, mispredict_cnt_o} !== {4'd1, 4'd1}) begin
      bad++;
      $display("FAIL alloc_stats got br=%0d mp=%0d exp br=1 mp=1", branch_cnt_o, mispredict_cnt_o);
    end
  endtask

  task automatic test_hysteresis;
    // cnt 2 -> 1: taken bit drops
    do_update(32'h40, 1'b0, 32'h0, 1'b1);
    set_lookup(32'h40);
    total++;
    if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b1, 1'b0, 32'h44}) begin
      bad++;
      $display("FAIL hyst_dec1 got hit=%b taken=%b next=%h exp hit=1 taken=0 next=00000044",
               pred_hit_o, pred_taken_o, pred_next_pc_o);
    end
    do_update(32'h40, 1'b0, 32'h0, 1'b0);  // cnt 0
    do_update(32'h40, 1'b0, 32'h0, 1'b0);  // cnt stays 0
    set_lookup(32'h40);
    total++;
    if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b1, 1'b0, 32'h44}) begin
      bad++;
      $display("FAIL hyst_floor got hit=%b taken=%b next=%h exp hit=1 taken=0 next=00000044",
               pred_hit_o, pred_taken_o, pred_next_pc_o);
    end
    // From 0 one taken update is not enough to flip if the floor held at 0
    do_update(32'h40, 1'b1, 32'h20, 1'b0);  // cnt 1
    set_lookup(32'h40);
    total++;
    if (pred_taken_o !== 1'b0) begin
      bad++;
      $display("FAIL hyst_inc1 got taken=%b exp taken=0", pred_taken_o);
    end
    do_update(32'h40, 1'b1, 32'h20, 1'b0);  // cnt 2
    set_lookup(32'h40);
    total++;
    if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b1, 1'b1, 32'h20}) begin
      bad++;
      $display("FAIL hyst_inc2 got hit=%b taken=%b next=%h exp hit=1 taken=1 next=00000020",
               pred_hit_o, pred_taken_o, pred_next_pc_o);
    end
    do_update(32'h40, 1'b1, 32'h20, 1'b1);  // cnt 3
    do_update(32'h40, 1'b1, 32'h20, 1'b1);  // cnt stays 3
    do_update(32'h40, 1'b0, 32'h0, 1'b1);   // cnt 2
    set_lookup(32'h40);
    total++;
    if (pred_taken_o !== 1'b1) begin
      bad++;
      $display("FAIL hyst_ceiling got taken=%b exp taken=1", pred_taken_o);
    end
    do_update(32'h40, 1'b0, 32'h0, 1'b1);   // cnt 1
    set_lookup(32'h40);
    total++;
    if (pred_taken_o !== 1'b0) begin
      bad++;
      $display("FAIL hyst_ceiling_dec got taken=%b exp taken=0", pred_taken_o);
    end
    do_update(32'h40, 1'b0, 32'h0, 1'b0);   // cnt 0
    // 11 branches so far; mispredicts: alloc, dec1, inc1, inc2, two ceiling decs
    total++;
    if ({branch_cnt_o, mispredict_cnt_o} !== {4'd11, 4'd6}) begin
      bad++;
      $display("FAIL hyst_stats got br=%0d mp=%0d exp br=11 mp=6", branch_cnt_o, mispredict_cnt_o);
    end
  endtask

  task automatic test_alias;
    set_lookup(32'h80);
    total++;
    if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b0, 1'b0, 32'h84}) begin
      bad++;
      $display("FAIL alias_miss got hit=%b taken=%b next=%h exp hit=0 taken=0 next=00000084",
               pred_hit_o, pred_taken_o, pred_next_pc_o);
    end
    do_update(32'h80, 1'b1, 32'h100, 1'b0);
    set_lookup(32'h80);
    total++;
    if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b1, 1'b1, 32'h100}) begin
      bad++;
      $display("FAIL alias_replace got hit=%b taken=%b next=%h exp hit=1 taken=1 next=00000100",
               pred_hit_o, pred_taken_o, pred_next_pc_o);
    end
    set_lookup(32'h40);
    total++;
    if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b0, 1'b0, 32'h44}) begin
      bad++;
      $display("FAIL alias_evicted got hit=%b taken=%b next=%h exp hit=0 taken=0 next=00000044",
               pred_hit_o, pred_taken_o, pred_next_pc_o);
    end
    do_update(32'hC0, 1'b0, 32'h999, 1'b0);
    set_lookup(32'h80);
    total++;
    if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b1, 1'b1, 32'h100}) begin
      bad++;
      $display("FAIL alias_nt_miss got hit=%b taken=%b next=%h exp hit=1 taken=1 next=00000100",
               pred_hit_o, pred_taken_o, pred_next_pc_o);
    end
    set_lookup(32'hC0);
    total++;
    if (pred_hit_o !== 1'b0) begin
      bad++;
      $display("FAIL alias_nt_noalloc got hit=%b exp hit=0", pred_hit_o);
    end
    total++;
    if ({branch_cnt_o, mispredict_cnt_o} !== {4'd13, 4'd7}) begin
      bad++;
      $display("FAIL alias_stats got br=%0d mp=%0d exp br=13 mp=7", branch_cnt_o, mispredict_cnt_o);
    end
  endtask

  task automatic test_same_cycle;
    do_update(32'h40, 1'b1, 32'h30, 1'b1);  // reallocate at cnt 2
    do_update(32'h40, 1'b0, 32'h0, 1'b1);   // cnt 1
    lookup_pc_i         = 32'h40;
    update_valid_i      = 1'b1;
    update_pc_i         = 32'h40;
    update_taken_i      = 1'b1;
    update_target_i     = 32'h60;
    update_pred_taken_i = 1'b0;
    #1;
    total++;
    if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b1, 1'b0, 32'h44}) begin
      bad++;
      $display("FAIL same_cycle_pre got hit=%b taken=%b next=%h exp hit=1 taken=0 next=00000044",
               pred_hit_o, pred_taken_o, pred_next_pc_o);
    end
    @(posedge clk_i);
    #1;
    update_valid_i = 1'b0;
    total++;
    if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b1, 1'b1, 32'h60}) begin
      bad++;
      $display("FAIL same_cycle_post got hit=%b taken=%b next=%h exp hit=1 taken=1 next=00000060",
               pred_hit_o, pred_taken_o, pred_next_pc_o);
    end
    // 16 branches would exceed 4 bits: branch count saturates at 15
    total++;
    if ({branch_cnt_o, mispredict_cnt_o} !== {4'd15, 4'd9}) begin
      bad++;
      $display("FAIL same_cycle_stats got br=%0d mp=%0d exp br=15 mp=9", branch_cnt_o, mispredict_cnt_o);
    end
  endtask

  task automatic test_stat_saturation;
    for (int i = 0; i < 20; i++) begin
      do_update(32'h204, 1'b1, 32'h300, 1'b0);
    end
    total++;
    if ({branch_cnt_o, mispredict_cnt_o} !== {4'd15, 4'd15}) begin
      bad++;
      $display("FAIL stat_saturate got br=%0d mp=%0d exp br=15 mp=15", branch_cnt_o, mispredict_cnt_o);
    end
    set_lookup(32'h204);
    total++;
    if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b1, 1'b1, 32'h300}) begin
      bad++;
      $display("FAIL stat_entry got hit=%b taken=%b next=%h exp hit=1 taken=1 next=00000300",
               pred_hit_o, pred_taken_o, pred_next_pc_o);
    end
  endtask

  task automatic test_reset_priority;
    reset_i             = 1'b1;
    update_valid_i      = 1'b1;
    update_pc_i         = 32'h44;
    update_taken_i      = 1'b1;
    update_target_i     = 32'h500;
    update_pred_taken_i = 1'b0;
    @(posedge clk_i);
    #1;
    reset_i        = 1'b0;
    update_valid_i = 1'b0;
    set_lookup(32'h44);
    total++;
    if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b0, 1'b0, 32'h48}) begin
      bad++;
      $display("FAIL rst_prio_update got hit=%b taken=%b next=%h exp hit=0 taken=0 next=00000048",
               pred_hit_o, pred_taken_o, pred_next_pc_o);
    end
    set_lookup(32'h40);
    total++;
    if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b0, 1'b0, 32'h44}) begin
      bad++;
      $display("FAIL rst_prio_clear40 got hit=%b taken=%b next=%h exp hit=0 taken=0 next=00000044",
               pred_hit_o, pred_taken_o, pred_next_pc_o);
    end
    set_lookup(32'h204);
    total++;
    if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b0, 1'b0, 32'h208}) begin
      bad++;
      $display("FAIL rst_prio_clear204 got hit=%b taken=%b next=%h exp hit=0 taken=0 next=00000208",
               pred_hit_o, pred_taken_o, pred_next_pc_o);
    end
    total++;
    if ({branch_cnt_o, mispredict_cnt_o} !== 8'h00) begin
      bad++;
      $display("FAIL rst_prio_stats got br=%0d mp=%0d exp br=0 mp=0", branch_cnt_o, mispredict_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_hysteresis();
    test_alias();
    test_same_cycle();
    test_stat_saturation();
    test_reset_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
